// File: rtl/hazard_match_gen_if.sv
// Decode-stage inputs and hazard-compare outputs exchanged between the
// pipeline control and the hazard match generator.
interface hazard_match_gen_if #(
    parameter int REG_BITS  = 4,
    parameter int CNT_WIDTH = 16
);
    logic [REG_BITS-1:0]  RA1D;
    logic [REG_BITS-1:0]  RA2D;
    logic [REG_BITS-1:0]  WA3D;
    logic                 RegWriteD;
    logic                 MemtoRegD;
    logic                 LDRstall;
    logic                 FlushE;
    logic                 Match_1E_M;
    logic                 Match_1E_W;
    logic                 Match_2E_M;
    logic                 Match_2E_W;
    logic                 Match_12D_E;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 MemtoRegE;
    logic [CNT_WIDTH-1:0] StallCount;

    modport master (
        output RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, LDRstall, FlushE,
        input  Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        input  RegWriteM, RegWriteW, MemtoRegE, StallCount
    );

    modport slave (
        input  RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, LDRstall, FlushE,
        output Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
        output RegWriteM, RegWriteW, MemtoRegE, StallCount
    );
endinterface

// File: rtl/hazard_match_gen.sv
// Tracks register addresses through E/M/W and produces the address compares
// the hazard unit uses for forwarding and load-use stalls, plus a bubble counter.
module hazard_match_gen #(
    parameter int REG_BITS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_match_gen_if.slave hz
);
    localparam logic [REG_BITS-1:0]  PC_ADDR = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [REG_BITS-1:0]  ra1_e_q, ra1_e_d;
    logic [REG_BITS-1:0]  ra2_e_q, ra2_e_d;
    logic [REG_BITS-1:0]  wa3_e_q, wa3_e_d;
    logic                 reg_write_e_q, reg_write_e_d;
    logic                 mem_to_reg_e_q, mem_to_reg_e_d;
    logic [REG_BITS-1:0]  wa3_m_q, wa3_m_d;
    logic                 reg_write_m_q, reg_write_m_d;
    logic [REG_BITS-1:0]  wa3_w_q, wa3_w_d;
    logic                 reg_write_w_q, reg_write_w_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 bubble;

    assign bubble = hz.LDRstall | hz.FlushE;

    always_comb begin
        ra1_e_d        = hz.RA1D;
        ra2_e_d        = hz.RA2D;
        wa3_e_d        = hz.WA3D;
        reg_write_e_d  = hz.RegWriteD;
        mem_to_reg_e_d = hz.MemtoRegD;
        if (bubble) begin
            ra1_e_d        = '0;
            ra2_e_d        = '0;
            wa3_e_d        = '0;
            reg_write_e_d  = 1'b0;
            mem_to_reg_e_d = 1'b0;
        end
        // M and W always advance; a bubble only replaces what enters E
        wa3_m_d       = wa3_e_q;
        reg_write_m_d = reg_write_e_q;
        wa3_w_d       = wa3_m_q;
        reg_write_w_d = reg_write_m_q;
        stall_cnt_d   = stall_cnt_q;
        if (bubble && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1_e_q        <= '0;
            ra2_e_q        <= '0;
            wa3_e_q        <= '0;
            reg_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            wa3_m_q        <= '0;
            reg_write_m_q  <= 1'b0;
            wa3_w_q        <= '0;
            reg_write_w_q  <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            ra1_e_q        <= ra1_e_d;
            ra2_e_q        <= ra2_e_d;
            wa3_e_q        <= wa3_e_d;
            reg_write_e_q  <= reg_write_e_d;
            mem_to_reg_e_q <= mem_to_reg_e_d;
            wa3_m_q        <= wa3_m_d;
            reg_write_m_q  <= reg_write_m_d;
            wa3_w_q        <= wa3_w_d;
            reg_write_w_q  <= reg_write_w_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // The PC is never a forwarding source, so an all-ones destination never matches
    assign hz.Match_1E_M  = (wa3_m_q != PC_ADDR) && (ra1_e_q == wa3_m_q);
    assign hz.Match_1E_W  = (wa3_w_q != PC_ADDR) && (ra1_e_q == wa3_w_q);
    assign hz.Match_2E_M  = (wa3_m_q != PC_ADDR) && (ra2_e_q == wa3_m_q);
    assign hz.Match_2E_W  = (wa3_w_q != PC_ADDR) && (ra2_e_q == wa3_w_q);
    assign hz.Match_12D_E = (wa3_e_q != PC_ADDR) &&
                            ((hz.RA1D == wa3_e_q) || (hz.RA2D == wa3_e_q));

    assign hz.RegWriteM  = reg_write_m_q;
    assign hz.RegWriteW  = reg_write_w_q;
    assign hz.MemtoRegE  = mem_to_reg_e_q;
    assign hz.StallCount = stall_cnt_q;
endmodule

// File: doc/hazard_match_gen.md
HAZARD_MATCH_GEN -- requirements
Module: hazard_match_gen

Interface
REQ-001 Parameter REG_BITS, default 4: width of register-file addresses.
REQ-002 Parameter CNT_WIDTH, default 16: width of the stall-event counter.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: asynchronous, active-low reset.
REQ-005 Port RA1D, RA2D  input  REG_BITS each: Decode-stage source register addresses.
REQ-006 Port WA3D  input  REG_BITS: Decode-stage destination register address.
REQ-007 Port RegWriteD, MemtoRegD  input  1 each: Decode-stage write-enable and load flags.
REQ-008 Port LDRstall  input  1: load-use stall returned by the hazard unit.
REQ-009 Port FlushE  input  1: branch-taken flush of the Execute stage.
REQ-010 Port Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  output  1 each: Execute-source vs Memory/Writeback-destination compares.
REQ-011 Port Match_12D_E  output  1: either Decode source equals the Execute destination.
REQ-012 Port RegWriteM, RegWriteW, MemtoRegE  output  1 each: pipelined control flags for the hazard unit.
REQ-013 Port StallCount  output  CNT_WIDTH: number of cycles in which a bubble was inserted into Execute.

Function
REQ-014 Block SHALL hold three register stages: E (RA1E, RA2E, WA3E, RegWriteE, MemtoRegE), M (WA3M, RegWriteM), W (WA3W, RegWriteW).
REQ-015 Each rising edge with reset high SHALL shift: M <- E fields, W <- M fields.
REQ-016 E SHALL load the D-stage inputs when LDRstall=0 and FlushE=0.
REQ-017 E SHALL load a bubble when LDRstall=1 or FlushE=1: all E fields set to 0.
REQ-018 A bubble SHALL still shift into M and W; an in-flight M/W instruction is never cancelled.
REQ-019 Match_1E_M SHALL be (RA1E==WA3M); Match_1E_W SHALL be (RA1E==WA3W); Match_2E_M and Match_2E_W are the same compares using RA2E.
REQ-020 Match_12D_E SHALL be (RA1D==WA3E) OR (RA2D==WA3E).
REQ-021 A compare SHALL force 0 when its destination address equals all-ones (PC, R15 at default width); the PC is never forwarded.
REQ-022 All Match outputs SHALL be combinational from current registered state and current D inputs, with zero cycles of latency.
REQ-023 Match outputs SHALL NOT be gated by RegWrite/MemtoReg; the hazard unit applies that qualification.
REQ-024 RegWriteM, RegWriteW, MemtoRegE SHALL be driven directly from their stage registers.
REQ-025 StallCount SHALL increment by 1 on each edge where LDRstall=1 or FlushE=1, and count once when both are asserted.
REQ-026 StallCount SHALL saturate at 2^CNT_WIDTH-1 and hold there; it never wraps.
REQ-027 LDRstall and FlushE asserted together SHALL give the same E result as either alone: a bubble.

Reset
REQ-028 reset low SHALL immediately clear all E, M, W fields and StallCount to 0, independent of clk.
REQ-029 While reset is low, RegWriteM, RegWriteW, MemtoRegE and StallCount SHALL read 0.
REQ-030 Match outputs during reset follow REQ-019..021 on the zero state; e.g. RA1D=0 gives Match_12D_E=1. This is harmless because RegWrite is 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight stages; the first edge after release loads E from the D inputs per REQ-016/017.

Verification
REQ-032 Forward chain: D {RA1=3, RA2=4, WA3=5, RegWrite=1}, then D {RA1=5, RA2=5, WA3=6} -> after 2 edges Match_1E_M=1, Match_2E_M=1, RegWriteM=1; after 3 edges Match_1E_W=1, Match_2E_W=1, RegWriteW=1.
REQ-033 Load-use: E holds {WA3E=2, MemtoRegE=1} and D RA2D=2 -> Match_12D_E=1. Drive LDRstall=1 for one edge -> E all-zero, MemtoRegE=0, StallCount=1.
REQ-034 PC exclusion: WA3M=15 and RA1E=15 -> Match_1E_M=0. WA3E=15 and RA1D=15 -> Match_12D_E=0.
REQ-035 Simultaneous LDRstall=1 and FlushE=1 for one edge -> E bubble, StallCount increments by exactly 1, M/W contents shift unchanged.
REQ-036 Saturation: with CNT_WIDTH=4, hold FlushE=1 for 20 edges -> StallCount=15 and stays 15.
REQ-037 Asynchronous reset: drop reset between edges with a non-zero pipeline -> all stage registers and StallCount read 0 before the next clk edge.
